// File: rtl/diag_collector.sv
// Multi-channel diagnostic collector: round-robin intake into a
// FIFO with duplicate suppression, saturating counters, first-error latch.
module diag_collector #(
    parameter int NCH          = 4,
    parameter int CODE_W       = 6,
    parameter int POS_W        = 16,
    parameter int LEN_W        = 8,
    parameter int DEPTH        = 16,
    parameter int CNT_W        = 16,
    parameter int DROP_ON_FULL = 0,
    parameter int DEDUP        = 1,
    localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          rpt_valid,
    output logic [NCH-1:0]          rpt_ready,
    input  logic [NCH*CODE_W-1:0]   rpt_code,
    input  logic [NCH-1:0]          rpt_sev,
    input  logic [NCH*POS_W-1:0]    rpt_pos,
    input  logic [NCH*LEN_W-1:0]    rpt_len,
    output logic                    diag_valid,
    input  logic                    diag_ready,
    output logic [CH_W-1:0]         diag_ch,
    output logic [CODE_W-1:0]       diag_code,
    output logic                    diag_sev,
    output logic [POS_W-1:0]        diag_pos,
    output logic [LEN_W-1:0]        diag_len,
    input  logic                    clr,
    output logic [CNT_W-1:0]        err_count,
    output logic [CNT_W-1:0]        warn_count,
    output logic [CNT_W-1:0]        drop_count,
    output logic                    first_valid,
    output logic [CODE_W-1:0]       first_code,
    output logic [POS_W-1:0]        first_pos
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = CH_W + CODE_W + 1 + POS_W + LEN_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [ENT_W-1:0]  head;
    logic [ENT_W-1:0]  wr_data;

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_next;
    logic              grant_any;
    logic [CH_W-1:0]   grant_idx;
    logic [CODE_W-1:0] sel_code;
    logic              sel_sev;
    logic [POS_W-1:0]  sel_pos;
    logic [LEN_W-1:0]  sel_len;

    logic              hist_valid;
    logic [CH_W-1:0]   hist_ch;
    logic [CODE_W-1:0] hist_code;
    logic [POS_W-1:0]  hist_pos;

    logic fifo_full;
    logic fifo_empty;
    logic eligible;
    logic accept;
    logic dup;
    logic keep;
    logic push;
    logic drop;
    logic pop;
    logic tally;

    // Round-robin pick: first valid at or above the pointer, else wrap to the lowest.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        sel_code  = '0;
        sel_sev   = 1'b0;
        sel_pos   = '0;
        sel_len   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!grant_any && rpt_valid[i] && CH_W'(i) >= rr_ptr) begin
                grant_any = 1'b1;
                grant_idx = CH_W'(i);
                sel_code  = rpt_code[i*CODE_W +: CODE_W];
                sel_sev   = rpt_sev[i];
                sel_pos   = rpt_pos[i*POS_W +: POS_W];
                sel_len   = rpt_len[i*LEN_W +: LEN_W];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!grant_any && rpt_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = CH_W'(i);
                sel_code  = rpt_code[i*CODE_W +: CODE_W];
                sel_sev   = rpt_sev[i];
                sel_pos   = rpt_pos[i*POS_W +: POS_W];
                sel_len   = rpt_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Eligibility uses the pre-pop occupancy, so a full FIFO never passes a report through.
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign eligible   = (DROP_ON_FULL != 0) || !fifo_full;
    assign accept     = grant_any && eligible;

    assign dup = (DEDUP != 0) && hist_valid &&
                 (hist_ch == grant_idx) &&
                 (hist_code == sel_code) &&
                 (hist_pos == sel_pos);

    assign keep  = accept && !dup;
    assign push  = keep && !fifo_full;
    assign drop  = keep && fifo_full;
    assign pop   = !fifo_empty && diag_ready;
    assign tally = keep && !clr;

    assign rr_next = (grant_idx == CH_W'(NCH - 1)) ? '0
                                                   : grant_idx + CH_W'(1);

    // One-hot accept strobe back to the granted channel.
    always_comb begin
        rpt_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            rpt_ready[i] = accept && (grant_idx == CH_W'(i));
        end
    end

    // Arbiter pointer moves past the channel just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_next;
        end
    end

    assign wr_data = {grant_idx, sel_code, sel_sev, sel_pos, sel_len};

    // Storage array; contents are meaningful only between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign diag_valid = !fifo_empty;

    // Head fields read as zero while the FIFO is empty.
    always_comb begin
        {diag_ch, diag_code, diag_sev, diag_pos, diag_len} = '0;
        if (!fifo_empty) begin
            {diag_ch, diag_code, diag_sev, diag_pos, diag_len} = head;
        end
    end

    // Last written entry, used to suppress back-to-back duplicates.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_valid <= 1'b0;
            hist_ch    <= '0;
            hist_code  <= '0;
            hist_pos   <= '0;
        end else if (push) begin
            hist_valid <= 1'b1;
            hist_ch    <= grant_idx;
            hist_code  <= sel_code;
            hist_pos   <= sel_pos;
        end
    end

    // Saturating status counters; clr wins over a same-cycle report.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_count  <= '0;
            warn_count <= '0;
            drop_count <= '0;
        end else if (tally) begin
            if (sel_sev && err_count != CNT_MAX) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (!sel_sev && warn_count != CNT_MAX) begin
                warn_count <= warn_count + CNT_W'(1);
            end
            if (drop && drop_count != CNT_MAX) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    // Capture the first counted error, including one that was dropped.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            first_valid <= 1'b0;
            first_code  <= '0;
            first_pos   <= '0;
        end else if (tally && sel_sev && !first_valid) begin
            first_valid <= 1'b1;
            first_code  <= sel_code;
            first_pos   <= sel_pos;
        end
    end

endmodule
